// File: rtl/nbit_register_file.sv
// Parametrised register file: one synchronous write port, two combinational read
// ports, optional hardwired-zero entry 0 and optional same-cycle write forwarding.

module nbit_dff (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// One n-bit word assembled from individual enable/reset flops.
module nbit_register #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  for (genvar b = 0; b < n; b++) begin : g_bit
    nbit_dff u_dff (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[b]),
      .q   (q[b])
    );
  end

endmodule

module nbit_register_file #(
  parameter int n        = 32,
  parameter int addr_w   = 5,
  parameter int depth    = 32,
  parameter int zero_reg = 1,
  parameter int bypass   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [n-1:0]      wr_data,
  input  logic [addr_w-1:0] rd_addr0,
  output logic [n-1:0]      rd_data0,
  input  logic [addr_w-1:0] rd_addr1,
  output logic [n-1:0]      rd_data1
);

  // One extra bit so depth == 2**addr_w is representable.
  localparam logic [addr_w:0] depth_lim = (addr_w + 1)'(depth);

  logic wr_in_range;
  logic wr_to_zero;
  logic wr_legal;

  assign wr_in_range = ({1'b0, wr_addr} < depth_lim);
  assign wr_to_zero  = (zero_reg != 0) && (wr_addr == '0);
  assign wr_legal    = !rst && wr_en && wr_in_range && !wr_to_zero;

  logic [n-1:0] entry_q [depth];

  for (genvar e = 0; e < depth; e++) begin : g_entry
    if ((zero_reg != 0) && (e == 0)) begin : g_zero
      assign entry_q[e] = '0;
    end else begin : g_reg
      logic load;
      assign load = wr_legal && (wr_addr == addr_w'(e));
      nbit_register #(.n(n)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .d   (wr_data),
        .q   (entry_q[e])
      );
    end
  end

  logic [n-1:0] stored0;
  logic [n-1:0] stored1;

  // Addresses with no implemented entry fall through to zero.
  always_comb begin
    stored0 = '0;
    stored1 = '0;
    for (int e = 0; e < depth; e++) begin
      if (rd_addr0 == addr_w'(e))
        stored0 = entry_q[e];
      if (rd_addr1 == addr_w'(e))
        stored1 = entry_q[e];
    end
  end

  logic fwd0;
  logic fwd1;

  // Forwarding reuses wr_legal so dropped writes are never forwarded.
  assign fwd0 = (bypass != 0) && wr_legal && (rd_addr0 == wr_addr);
  assign fwd1 = (bypass != 0) && wr_legal && (rd_addr1 == wr_addr);

  assign rd_data0 = rst ? '0 : (fwd0 ? wr_data : stored0);
  assign rd_data1 = rst ? '0 : (fwd1 ? wr_data : stored1);

endmodule

// File: tb/tb_nbit_register_file.sv
// Directed and scoreboard-checked bench for three register-file configurations
// sharing one stimulus stream.

module tb_nbit_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;

  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
  logic [31:0] obs0 [3];
  logic [31:0] obs1 [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: zero_reg+bypass, depth 32; 1: plain, no bypass; 2: depth 20.
  int          cfg_depth [3] = '{32, 32, 20};
  bit          cfg_zero  [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mem [3][32];

  always #5 clk = ~clk;

  nbit_register_file #(.n(32), .addr_w(5), .depth(32), .zero_reg(1), .bypass(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(a_rd0), .rd_addr1(rd_addr1), .rd_data1(a_rd1));

  nbit_register_file #(.n(32), .addr_w(5), .depth(32), .zero_reg(0), .bypass(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(b_rd0), .rd_addr1(rd_addr1), .rd_data1(b_rd1));

  nbit_register_file #(.n(32), .addr_w(5), .depth(20), .zero_reg(1), .bypass(1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(c_rd0), .rd_addr1(rd_addr1), .rd_data1(c_rd1));

  assign obs0[0] = a_rd0;
  assign obs0[1] = b_rd0;
  assign obs0[2] = c_rd0;
  assign obs1[0] = a_rd1;
  assign obs1[1] = b_rd1;
  assign obs1[2] = c_rd1;

  task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
    rst      = r;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = ra0;
    rd_addr1 = ra1;
  endtask

  // Scoreboard commit of the current inputs, then advance one clock.
  task automatic step;
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        for (int e = 0; e < 32; e++) mem[c][e] = 32'h0;
      end else if (wr_en && (int'(wr_addr) < cfg_depth[c]) && !(cfg_zero[c] && wr_addr == 5'd0)) begin
        mem[c][wr_addr] = wr_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_read(input int c, input logic [4:0] a);
    if (rst) return 32'h0;
    if (int'(a) >= cfg_depth[c]) return 32'h0;
    if (cfg_zero[c] && a == 5'd0) return 32'h0;
    if (cfg_byp[c] && wr_en && wr_addr == a) return wr_data;
    return mem[c][a];
  endfunction

  task automatic test_reset;
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    for (int a = 1; a < 32; a++) begin
      set_in(1'b0, 1'b1, 5'(a), 32'hDEADBEEF, 5'd0, 5'd0);
      step();
    end
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h0 || obs1[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_comb inst=%0d got=%h/%h exp=0", i, obs0[i], obs1[i]);
      end
    end
    step();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs0[i] !== 32'h0 || obs1[i] !== 32'h0) begin
          errors++;
          $display("[TB] FAIL reset_clear inst=%0d addr=%0d got=%h/%h exp=0", i, a, obs0[i], obs1[i]);
        end
      end
    end
  endtask

  task automatic test_basic;
    logic [31:0] exp1 [3];
    exp1 = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    set_in(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd0, 5'd0);
    step();
    set_in(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
    step();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h12345678 || obs1[i] !== exp1[i]) begin
        errors++;
        $display("[TB] FAIL basic_rw inst=%0d got=%h/%h exp=12345678/%h", i, obs0[i], obs1[i], exp1[i]);
      end
    end
    rd_addr0 = 5'd6;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL basic_untouched inst=%0d got=%h exp=0", i, obs0[i]);
      end
    end
  endtask

  task automatic test_zero_reg;
    logic [31:0] exp_next [3];
    exp_next = '{32'h0, 32'hAAAA5555, 32'h0};
    set_in(1'b0, 1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h0 || obs1[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL zero_same_cycle inst=%0d got=%h/%h exp=0", i, obs0[i], obs1[i]);
      end
    end
    step();
    wr_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== exp_next[i] || obs1[i] !== exp_next[i]) begin
        errors++;
        $display("[TB] FAIL zero_next_cycle inst=%0d got=%h/%h exp=%h", i, obs0[i], obs1[i], exp_next[i]);
      end
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_same [3];
    exp_same = '{32'h22222222, 32'h11111111, 32'h22222222};
    set_in(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    step();
    set_in(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== exp_same[i] || obs1[i] !== exp_same[i]) begin
        errors++;
        $display("[TB] FAIL bypass_same inst=%0d got=%h/%h exp=%h", i, obs0[i], obs1[i], exp_same[i]);
      end
    end
    step();
    wr_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h22222222 || obs1[i] !== 32'h22222222) begin
        errors++;
        $display("[TB] FAIL bypass_next inst=%0d got=%h/%h exp=22222222", i, obs0[i], obs1[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp_same [3];
    logic [31:0] exp_next [3];
    exp_same = '{32'hCAFEF00D, 32'h0, 32'h0};
    exp_next = '{32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
    set_in(1'b0, 1'b1, 5'd25, 32'hCAFEF00D, 5'd25, 5'd5);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== exp_same[i] || obs1[i] !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL oor_same inst=%0d got=%h/%h exp=%h/12345678", i, obs0[i], obs1[i], exp_same[i]);
      end
    end
    step();
    wr_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== exp_next[i]) begin
        errors++;
        $display("[TB] FAIL oor_next inst=%0d got=%h exp=%h", i, obs0[i], exp_next[i]);
      end
    end
    for (int a = 0; a < 20; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(19 - a);
      #1;
      checks++;
      if (c_rd0 !== exp_read(2, 5'(a)) || c_rd1 !== exp_read(2, 5'(19 - a))) begin
        errors++;
        $display("[TB] FAIL oor_entries addr=%0d got=%h/%h exp=%h/%h", a, c_rd0, c_rd1,
                 exp_read(2, 5'(a)), exp_read(2, 5'(19 - a)));
      end
    end
  endtask

  task automatic test_write_during_reset;
    set_in(1'b0, 1'b1, 5'd3, 32'h55555555, 5'd0, 5'd0);
    step();
    set_in(1'b1, 1'b1, 5'd3, 32'h0F0F0F0F, 5'd3, 5'd3);
    step();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs0[i] !== 32'h0 || obs1[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL wr_during_rst inst=%0d got=%h/%h exp=0", i, obs0[i], obs1[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] wa;
    for (int k = 0; k < 1000; k++) begin
      wa = 5'($urandom_range(31));
      set_in(($urandom_range(63) == 0), 1'($urandom_range(1)), wa, $urandom,
             ($urandom_range(1) == 1) ? wa : 5'($urandom_range(31)),
             ($urandom_range(2) == 0) ? wa : 5'($urandom_range(31)));
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs0[i] !== exp_read(i, rd_addr0) || obs1[i] !== exp_read(i, rd_addr1)) begin
          errors++;
          $display("[TB] FAIL random k=%0d inst=%0d got=%h/%h exp=%h/%h", k, i, obs0[i], obs1[i],
                   exp_read(i, rd_addr0), exp_read(i, rd_addr1));
        end
      end
      step();
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++)
      for (int e = 0; e < 32; e++) mem[c][e] = 32'h0;
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_out_of_range();
    test_write_during_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
